// File: rtl/pipe_sequencer.sv
// -----------------------------------------------------------------------------
// pipe_sequencer
//   Moves microinstructions from decode (stage 2) through stages 3, 4 and 5.
//   It drives the C/T control words used by the hazard/branch-notify unit and
//   owns the fetch PC. It inserts bubbles while HOLD is asserted and flushes
//   on a taken branch. It also keeps a saturating count of stall cycles and
//   raises a sticky flag when HOLD persists long enough to indicate deadlock.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous reset, active-high
//   hold_i           in   HOLD request from hazard unit (combinational)
//   branch_take_i    in   taken branch resolved this cycle
//   branch_target_i  in   PC_W  target PC for a taken branch
//   v2_i             in   stage-2 microinstruction valid
//   c2_i             in   6     stage-2 destination field C
//   t2_i             in   7     stage-2 T bits
//   pc_o             out  PC_W  fetch address (registered)
//   fetch_en_o       out  fetch/decode may accept a new word (from state)
//   stall_o          out  freeze stage 2 and PC (combinational)
//   flush_o          out  kill stage-2 contents (registered pulse)
//   c3_o..c5_o       out  6     stage 3/4/5 C fields (registered)
//   t3_o..t5_o       out  7     stage 3/4/5 T fields, 0 = bubble (registered)
//   state_o          out  2     00 RUN, 01 HOLD, 10 FLUSH (registered)
//   stall_cnt_o      out  CNT_W saturating HOLD-stall cycle count (registered)
//   hold_err_o       out  sticky deadlock flag (registered)
// -----------------------------------------------------------------------------
module pipe_sequencer #(
  parameter int PC_W      = 8,
  parameter int FLUSH_CYC = 1,
  parameter int MAX_HOLD  = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             branch_take_i,
  input  logic [PC_W-1:0]  branch_target_i,
  input  logic             v2_i,
  input  logic [5:0]       c2_i,
  input  logic [6:0]       t2_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             fetch_en_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic [5:0]       c3_o,
  output logic [5:0]       c4_o,
  output logic [5:0]       c5_o,
  output logic [6:0]       t3_o,
  output logic [6:0]       t4_o,
  output logic [6:0]       t5_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             hold_err_o
);

  // The flush counter holds the remaining FLUSH cycles minus one. It therefore
  // needs $clog2(FLUSH_CYC) bits, and at least one bit.
  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  // The hold-run counter must be able to represent MAX_HOLD itself.
  localparam int HR_W = $clog2(MAX_HOLD + 1);

  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYC - 1);
  localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [5:0]       r_c3;
  logic [5:0]       r_c4;
  logic [5:0]       r_c5;
  logic [6:0]       r_t3;
  logic [6:0]       r_t4;
  logic [6:0]       r_t5;
  logic [5:0]       w_c3_nxt;
  logic [6:0]       w_t3_nxt;
  logic             r_flush;
  logic             w_flush_nxt;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [FC_W-1:0]  w_flush_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic [HR_W-1:0]  r_hold_run;
  logic [HR_W-1:0]  w_hold_run_nxt;
  logic             r_hold_err;
  logic             w_hold_err_nxt;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: branch outranks hold, and FLUSH ignores hold entirely
  always_comb begin
    w_state_nxt = r_state;
    if (branch_take_i) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN, ST_HOLD: begin
          if (hold_i) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_FLUSH;
          end
        end
        default: begin
          // An illegal encoding recovers to RUN. This cycle still produces a bubble.
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Datapath next values: stage-3 load, PC, flush pulse, stall and watchdog counters
  always_comb begin
    w_pc_nxt        = r_pc;
    w_c3_nxt        = 6'd0;
    w_t3_nxt        = 7'd0;
    w_flush_nxt     = 1'b0;
    w_flush_cnt_nxt = r_flush_cnt;
    w_stall_cnt_nxt = r_stall_cnt;
    w_hold_run_nxt  = '0;
    w_hold_err_nxt  = r_hold_err;
    if (branch_take_i) begin
      // Redirect fetch and restart the FLUSH window. The stage-3 slot becomes a bubble.
      w_pc_nxt        = branch_target_i;
      w_flush_nxt     = 1'b1;
      w_flush_cnt_nxt = FC_LOAD;
    end else begin
      case (r_state)
        ST_RUN, ST_HOLD: begin
          if (hold_i) begin
            // Stage 2 and the PC are frozen externally through stall_o. Stage 3 gets a bubble.
            if (r_stall_cnt != CNT_MAX) begin
              w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
            end else begin
              w_stall_cnt_nxt = r_stall_cnt;
            end
            if (r_hold_run != HR_MAX) begin
              w_hold_run_nxt = r_hold_run + HR_W'(1);
            end else begin
              w_hold_run_nxt = r_hold_run;
            end
            if (w_hold_run_nxt == HR_MAX) begin
              w_hold_err_nxt = 1'b1;
            end else begin
              w_hold_err_nxt = r_hold_err;
            end
          end else begin
            if (v2_i) begin
              w_c3_nxt = c2_i;
              w_t3_nxt = t2_i;
              w_pc_nxt = r_pc + PC_W'(1);
            end else begin
              w_c3_nxt = 6'd0;
              w_t3_nxt = 7'd0;
            end
          end
        end
        ST_FLUSH: begin
          // Stage-2 content is dead and hold is ignored, so only the window counts down.
          if (r_flush_cnt != '0) begin
            w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
          end else begin
            w_flush_cnt_nxt = r_flush_cnt;
          end
        end
        default: begin
          w_flush_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Datapath registers. Stages 4 and 5 shift every cycle so writers always drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_c3        <= 6'd0;
      r_c4        <= 6'd0;
      r_c5        <= 6'd0;
      r_t3        <= 7'd0;
      r_t4        <= 7'd0;
      r_t5        <= 7'd0;
      r_flush     <= 1'b0;
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
      r_hold_run  <= '0;
      r_hold_err  <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_c5        <= r_c4;
      r_t5        <= r_t4;
      r_c4        <= r_c3;
      r_t4        <= r_t3;
      r_c3        <= w_c3_nxt;
      r_t3        <= w_t3_nxt;
      r_flush     <= w_flush_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_hold_run  <= w_hold_run_nxt;
      r_hold_err  <= w_hold_err_nxt;
    end
  end

  // stall_o is asserted in both RUN and HOLD. The held word must stay frozen
  // for the whole HOLD episode, and not only on its first cycle.
  assign stall_o     = hold_i & (r_state != ST_FLUSH) & ~branch_take_i;
  assign fetch_en_o  = (r_state != ST_FLUSH);
  assign pc_o        = r_pc;
  assign flush_o     = r_flush;
  assign c3_o        = r_c3;
  assign c4_o        = r_c4;
  assign c5_o        = r_c5;
  assign t3_o        = r_t3;
  assign t4_o        = r_t4;
  assign t5_o        = r_t5;
  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;
  assign hold_err_o  = r_hold_err;

endmodule
